// File: rtl/ex_stage_alu_arb.sv
// ex_stage_alu_arb: two-port arbiter for a shared ALU with a 2-entry in-order response FIFO.
module ex_stage_alu_arb #(
  parameter int ALU_W = 12,
  parameter int BJ_W = 8,
  parameter int TAG_W = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [63:0]      req0_op1,
  input  logic [63:0]      req0_op2,
  input  logic [ALU_W-1:0] req0_alu_info,
  input  logic             req0_word,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [63:0]      req1_op1,
  input  logic [63:0]      req1_op2,
  input  logic [ALU_W-1:0] req1_alu_info,
  input  logic             req1_word,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [63:0]      alu_op1,
  output logic [63:0]      alu_op2,
  output logic [ALU_W-1:0] alu_info,
  output logic             alu_is_word,
  input  logic [63:0]      alu_result,
  input  logic [BJ_W-1:0]  alu_bj,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [63:0]      rsp_result,
  output logic [BJ_W-1:0]  rsp_bj
);
  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [63:0]      result;
    logic [BJ_W-1:0]  bj;
  } entry_t;
  entry_t mem [2];
  logic wptr, rptr;
  logic [1:0] count;
  logic [2:0] starve_cnt;
  logic space, pri1, grant0, grant1, push, pop;
  // grants are gated by rst so nothing is accepted or driven while reset is held
  always_comb begin
    space = (count < 2'd2) | rsp_ready;
    pri1 = (starve_cnt == 3'(STARVE_LIMIT)) & req1_valid;
    grant0 = rst & space & req0_valid & !pri1;
    grant1 = rst & space & req1_valid & (pri1 | !req0_valid);
    req0_ready = grant0;
    req1_ready = grant1;
    alu_op1 = grant0 ? req0_op1 : grant1 ? req1_op1 : '0;
    alu_op2 = grant0 ? req0_op2 : grant1 ? req1_op2 : '0;
    alu_info = grant0 ? req0_alu_info : grant1 ? req1_alu_info : '0;
    alu_is_word = grant0 ? req0_word : grant1 & req1_word;
    push = grant0 | grant1;
    pop = rsp_valid & rsp_ready;
  end
  assign rsp_valid = count != 2'd0;
  assign {rsp_id, rsp_tag, rsp_result, rsp_bj} = mem[rptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      count <= 2'd0;
      starve_cnt <= 3'd0;
    end else begin
      if (push) mem[wptr] <= '{grant1, grant1 ? req1_tag : req0_tag, alu_result, alu_bj};
      if (push) wptr <= !wptr;
      if (pop) rptr <= !rptr;
      count <= count + 2'(push) - 2'(pop);
      if (grant1 | !req1_valid) starve_cnt <= 3'd0;
      else if (starve_cnt != 3'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 3'd1;
    end
  end
endmodule

// File: doc/ex_stage_alu_arb.md
# ex_stage_alu_arb

Arbiter and result buffer that shares one ex_stage_alu instance between two requesters: port 0 is the main EX pipeline, port 1 is the auxiliary unit (address/branch-target helper). Each cycle it selects at most one request and drives the shared ALU's operand and control inputs. It captures the ALU's combinational result into a 2-entry in-order response FIFO. Port 0 has fixed priority, bounded by a starvation counter that promotes port 1.

## Interface
Parameters:
- ALU_W, 12, width of the one-hot ALU operation vector (alu_info).
- BJ_W, 8, width of the branch/jump flag vector (bj_data).
- TAG_W, 4, requester-supplied tag width, returned unchanged.
- STARVE_LIMIT, 4, cycles port 1 may wait before it gets priority (1..7).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid is also high.
- reqN_op1, reqN_op2  in  64  operands.
- reqN_alu_info  in  ALU_W  one-hot operation.
- reqN_word  in  1  32-bit word operation.
- reqN_tag  in  TAG_W  opaque tag.
- alu_op1, alu_op2  out  64  to the shared ALU.
- alu_info  out  ALU_W  to the shared ALU.
- alu_is_word  out  1  to the shared ALU.
- alu_result  in  64  from the shared ALU, same cycle.
- alu_bj  in  BJ_W  from the shared ALU, same cycle.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accepts head.
- rsp_id  out  1  requester index of head.
- rsp_tag  out  TAG_W  tag of head.
- rsp_result  out  64  result of head.
- rsp_bj  out  BJ_W  branch flags of head.

## Operation
- space = (count < 2) | rsp_ready. No grant is issued when space is low.
- Priority: port 1 wins when starve_cnt == STARVE_LIMIT. Otherwise port 0 wins whenever req0_valid is high.
- grantN = space & reqN_valid & (port N selected). reqN_ready = grantN. At most one grant per cycle.
- ALU drive:
  - With a grant, the muxed operands, info and word flag of the granted port go to the ALU.
  - With no grant, alu_op1, alu_op2, alu_info and alu_is_word are all 0, so the ALU output is 0.
- Push: on a grant, {id, tag, alu_result, alu_bj} is written at the FIFO tail.
- Pop: when rsp_valid & rsp_ready.
- Push and pop in the same cycle are allowed in every count state, including count == 2. Count is unchanged and order is preserved.
- FIFO: 2 entries, with 1-bit write and read pointers that wrap, and a 2-bit count. The head is always in registers.
- starve_cnt (3 bits):
  - Increments, saturating at STARVE_LIMIT, when req1_valid & !grant1.
  - Cleared when grant1 or !req1_valid.
- Requesters must hold valid and payload stable until ready. The arbiter does not check this.

## Timing
- Reset (rst low, asynchronous) sets:
  - count = 0, both pointers = 0, starve_cnt = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_tag = 0, rsp_result = 0, rsp_bj = 0.
  - reqN_ready = 0 while rst is low.
- Reset mid-operation discards all buffered responses, with no partial output.
- Latency: a request accepted in cycle N appears at the FIFO head with rsp_valid = 1 in cycle N+1, provided the FIFO was empty or drained ahead of it.
- Throughput: one accept per cycle while rsp_ready is held high.
- Full (count == 2) with rsp_ready low: both readies are 0, and the head and second entry are held stable.
- reqN_ready depends combinationally on rsp_ready, reqN_valid and state. Consumers must not make rsp_ready depend on reqN_ready.

## Test plan
- Reset: hold rst low 3 cycles with req0_valid = 1 -> rsp_valid = 0, reqN_ready = 0, alu_info = 0. Release rst -> req0_ready = 1 in the first cycle.
- Single op: port 0 sends op1 = 5, op2 = 3, ADD, tag 0xA, rsp_ready = 1 -> next cycle rsp_valid = 1, rsp_result = 8, rsp_id = 0, rsp_tag = 0xA.
- Simultaneous requests: both ports valid for one cycle (port 0 SUB 10-4, port 1 XOR 0xF0^0x0F), port 0 then drops -> port 0 is granted first (result 6), port 1 next cycle (result 0xFF, rsp_id = 1). Order is preserved.
- Starvation: port 0 valid every cycle and port 1 valid from cycle 0 -> port 1 waits exactly 4 cycles, is granted in cycle 4, and starve_cnt clears.
- Backpressure: rsp_ready = 0, three back-to-back port 0 requests -> two are accepted and the third sees ready = 0. Raise rsp_ready -> pop and push happen in the same cycle, and results appear in issue order.
- Word shift and reset mid-flight: port 1 SLL word with op1 = 0x8000_0001, op2 = 1 -> rsp_result = 0x0000_0000_0000_0002. Then fill the FIFO and pulse rst for 1 cycle -> rsp_valid = 0 immediately, and the buffered entries are never emitted.
